// File: rtl/acc_b_muldiv_seq.sv
// Multi-cycle MUL AB / DIV AB sequencer: latches ACC/B, iterates shift-add or
// restoring division, then issues one-cycle ACC/B byte writes and PSW flag update.
module acc_b_muldiv_seq #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_is_div,
  input  logic [7:0] i_acc,
  input  logic [7:0] i_b,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_acc_byte,
  output logic       o_acc_wr,
  output logic [7:0] o_b_byte,
  output logic       o_b_wr,
  output logic       o_ov,
  output logic       o_flag_wr
);

  localparam int unsigned N = 8 / BITS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        op_q, op_d;
  logic [15:0] prod_q, prod_d;
  logic [7:0]  rem_q, rem_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  acc_byte_q, acc_byte_d;
  logic        acc_wr_q, acc_wr_d;
  logic [7:0]  b_byte_q, b_byte_d;
  logic        b_wr_q, b_wr_d;
  logic        ov_q, ov_d;
  logic        flag_wr_q, flag_wr_d;

  logic [15:0] p;
  logic [7:0]  aa;
  logic [7:0]  r;
  logic [8:0]  trial;
  logic [3:0]  shamt;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    acc_byte_d = acc_byte_q;
    acc_wr_d   = 1'b0;
    b_byte_d   = b_byte_q;
    b_wr_d     = 1'b0;
    ov_d       = ov_q;
    flag_wr_d  = 1'b0;
    p          = prod_q;
    aa         = a_q;
    r          = rem_q;
    trial      = '0;
    shamt      = '0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d    = i_acc;
          b_d    = i_b;
          op_d   = i_is_div;
          cnt_d  = '0;
          prod_d = '0;
          rem_d  = '0;
          busy_d = 1'b1;
          if (i_is_div && (i_b == 8'h00)) begin
            state_d   = WRITE;
            done_d    = 1'b1;
            flag_wr_d = 1'b1;
            ov_d      = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        // a doubles as multiplier shifter (MUL) and dividend/quotient shifter (DIV)
        for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
          if (op_q) begin
            trial = {r, aa[7]} - {1'b0, b_q};
            if (!trial[8]) begin
              r  = trial[7:0];
              aa = {aa[6:0], 1'b1};
            end else begin
              r  = {r[6:0], aa[7]};
              aa = {aa[6:0], 1'b0};
            end
          end else begin
            shamt = 4'(32'(cnt_q) * BITS_PER_CYCLE + j);
            if (aa[0]) begin
              p = p + ({8'h00, b_q} << shamt);
            end
            aa = {1'b0, aa[7:1]};
          end
        end
        prod_d = p;
        a_d    = aa;
        rem_d  = r;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(N - 1)) begin
          state_d   = WRITE;
          done_d    = 1'b1;
          flag_wr_d = 1'b1;
          acc_wr_d  = 1'b1;
          b_wr_d    = 1'b1;
          if (op_q) begin
            acc_byte_d = aa;
            b_byte_d   = r;
            ov_d       = 1'b0;
          end else begin
            acc_byte_d = p[7:0];
            b_byte_d   = p[15:8];
            ov_d       = |p[15:8];
          end
        end
      end

      WRITE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      prod_q     <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_byte_q <= '0;
      acc_wr_q   <= 1'b0;
      b_byte_q   <= '0;
      b_wr_q     <= 1'b0;
      ov_q       <= 1'b0;
      flag_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      acc_byte_q <= acc_byte_d;
      acc_wr_q   <= acc_wr_d;
      b_byte_q   <= b_byte_d;
      b_wr_q     <= b_wr_d;
      ov_q       <= ov_d;
      flag_wr_q  <= flag_wr_d;
    end
  end

  // Strobes are registered but masked by a reset arriving during the WRITE cycle.
  assign o_busy     = busy_q;
  assign o_done     = done_q & ~i_rst;
  assign o_acc_byte = acc_byte_q;
  assign o_acc_wr   = acc_wr_q & ~i_rst;
  assign o_b_byte   = b_byte_q;
  assign o_b_wr     = b_wr_q & ~i_rst;
  assign o_ov       = ov_q;
  assign o_flag_wr  = flag_wr_q & ~i_rst;

endmodule

// File: doc/acc_b_muldiv_seq.md
Name: acc_b_muldiv_seq

Overview:
Multi-cycle sequencer for the 8051 MUL AB and DIV AB instructions.
- Latches ACC and B at start and iterates a shift-add multiplier or a restoring divider.
- Issues one-cycle byte-write strobes toward the accumulator and B registers, plus OV/CY flag updates toward PSW.
- Sits between instruction decode and the SFR write ports; decode stalls on o_busy.

Parameters:
BITS_PER_CYCLE, 1, operand bits processed per CALC cycle; legal values 1, 2, 4, 8; iteration count N = 8/BITS_PER_CYCLE.

Ports:
i_clk  input  1  clock; all state changes on rising edge
i_rst  input  1  reset, synchronous, active-high
i_start  input  1  start request, sampled only in IDLE
i_is_div  input  1  0 = MUL AB, 1 = DIV AB; sampled with i_start
i_acc  input  8  current ACC value, sampled with i_start
i_b  input  8  current B value, sampled with i_start
o_busy  output  1  high in CALC and WRITE
o_done  output  1  one-cycle pulse in WRITE
o_acc_byte  output  8  result byte for ACC (MUL low byte / quotient)
o_acc_wr  output  1  ACC byte-write strobe, one cycle
o_b_byte  output  8  result byte for B (MUL high byte / remainder)
o_b_wr  output  1  B byte-write strobe, one cycle
o_ov  output  1  overflow flag value, valid with o_flag_wr
o_flag_wr  output  1  strobe: PSW.OV <= o_ov, PSW.CY <= 0

Behaviour:
- Clock and reset: one clock (i_clk); reset synchronous, active-high (i_rst).
- Reset values: state IDLE, iteration counter 0, all outputs 0 including result bytes. Reset has priority over every other input.
- States: IDLE, CALC, WRITE.
- IDLE, i_start = 1:
  - Latch a = i_acc, b = i_b, op = i_is_div.
  - DIV with i_b == 0 goes directly to WRITE (divide-by-zero path).
  - Otherwise go to CALC with counter = 0.
  - i_start = 0 in IDLE: hold.
- CALC, MUL (shift-add, LSB first):
  - 16-bit product accumulator initialised to 0.
  - Each step: if multiplier bit set, add b shifted into position; BITS_PER_CYCLE steps per clock.
- CALC, DIV (restoring, MSB first):
  - 9-bit partial remainder.
  - Each step: shift in next dividend bit, trial-subtract b; if non-negative, keep the difference and set the quotient bit to 1, otherwise 0.
- CALC exit: counter increments per clock; after N CALC cycles go to WRITE.
- WRITE, normal MUL:
  - o_acc_byte = product[7:0], o_b_byte = product[15:8], o_acc_wr = o_b_wr = 1.
  - o_ov = (product[15:8] != 0).
- WRITE, normal DIV:
  - o_acc_byte = quotient, o_b_byte = remainder, both strobes 1, o_ov = 0.
- WRITE, divide-by-zero: o_acc_wr = o_b_wr = 0 (ACC and B unchanged), o_ov = 1.
- WRITE, all cases: o_flag_wr = 1, o_done = 1. Next edge returns to IDLE.
- Strobe width: o_done, o_acc_wr, o_b_wr and o_flag_wr are high for exactly one cycle and are registered.
- Result byte retention: o_acc_byte and o_b_byte hold their last values outside WRITE.
- Latency, start edge to o_done cycle:
  - Normal op: N + 1 cycles (9 for BITS_PER_CYCLE = 1, 3 for 4).
  - Divide-by-zero: 1 cycle.
- o_busy: high from the cycle after the accepted start through the WRITE cycle inclusive.
- i_start while busy: ignored and not queued. i_start is accepted in the cycle after WRITE (IDLE) at the earliest.
- Operand stability: i_acc and i_b changing during CALC have no effect; operands are latched.
- Reset mid-CALC or in WRITE: return to IDLE next edge. No write strobes are issued afterwards, and a WRITE-cycle strobe coincident with i_rst is suppressed.
- Overflow-free arithmetic: the 8x8 product fits 16 bits; quotient and remainder each fit 8 bits.

Test Plan:
- MUL A = 0x50, B = 0xA0, BITS_PER_CYCLE = 1 -> o_done 9 cycles after start; o_acc_byte = 0x00, o_b_byte = 0x32, both strobes high, o_ov = 1, o_flag_wr = 1.
- MUL A = 0x0C, B = 0x10 -> o_acc_byte = 0xC0, o_b_byte = 0x00, o_ov = 0; o_busy high for exactly 9 cycles.
- DIV A = 0xFB, B = 0x12 -> o_acc_byte = 0x0D, o_b_byte = 0x11, o_ov = 0, both strobes high. DIV A = 0x07, B = 0x09 -> 0x00 / 0x07.
- DIV A = 0x45, B = 0x00 -> o_done 1 cycle after start, o_ov = 1, o_flag_wr = 1, o_acc_wr = o_b_wr = 0.
- Start pulse at cycle 3 of a MUL, then i_rst at cycle 5 of a second op -> extra start ignored (single o_done). After reset: o_busy = 0 next cycle, no strobes, a new start is accepted normally.
- BITS_PER_CYCLE = 4, MUL 0xFF * 0xFF -> o_done 3 cycles after start, o_acc_byte = 0x01, o_b_byte = 0xFE, o_ov = 1.
